// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared types and elaboration helpers for the sipo_deser deserializer
// Purpose: holds the output-stage state enum and the width helpers used to size
// the beat counter and validate the IN_W/OUT_W pairing at elaboration time.
package sipo_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Ceiling log2. Returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return r;
    endfunction

    // Beat counter width for n beats per frame; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

    // A legal configuration packs at least two whole beats into one word.
    function automatic bit cfg_ok(input int in_w, input int out_w);
        return (in_w >= 1) && (out_w % in_w == 0) && (out_w / in_w >= 2);
    endfunction

endpackage

// File: rtl/sipo_out_reg.sv
// rtl/sipo_out_reg.sv - double-buffer output holding stage for sipo_deser
// Purpose: holds one completed word until the consumer takes it, and produces
// the input stall term so the final beat of a frame is only taken when the
// word it completes has somewhere to go.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   clear          - synchronous flush (priority over load/drain)
//   load/load_data - a frame completed this cycle, with its word
//   last_beat      - the fill side holds N-1 beats
//   out_ready      - consumer handshake
//   out_valid/out_data - held word
//   in_ready       - upstream may present a beat
module sipo_out_reg
    import sipo_pkg::*;
#(
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [OUT_W-1:0] load_data,
    input  logic             last_beat,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    output logic             in_ready
);

    out_state_e       state_q, state_d;
    logic [OUT_W-1:0] data_q, data_d;

    // Only a completing beat needs space in this stage; partial frames never stall.
    assign in_ready = !(last_beat && (state_q == FULL) && !out_ready);

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (clear) begin
            state_d = EMPTY;
            data_d  = '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (load) begin
                        state_d = FULL;
                        data_d  = load_data;
                    end
                end
                FULL: begin
                    // A load while FULL implies out_ready (in_ready gates it),
                    // so the old word leaves on the same edge: no bubble.
                    if (load) begin
                        data_d = load_data;
                    end else if (out_ready) begin
                        state_d = EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == FULL);
    assign out_data  = data_q;

endmodule

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - parametrised serial-in/parallel-out deserializer, top level
// Purpose: shifts N = OUT_W/IN_W input beats into a fill register and hands each
// completed word to a double-buffered output stage.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   clear                - synchronous flush, drops any beat in the same cycle
//   in_valid/in_data/in_ready    - beat input handshake
//   out_valid/out_data/out_ready - word output handshake
//   beat_cnt             - beats held for the current partial frame
//   overrun              - sticky: a beat was offered while in_ready was low
module sipo_deser
    import sipo_pkg::*;
#(
    parameter  int IN_W      = 2,
    parameter  int OUT_W     = 8,
    parameter  bit MSB_FIRST = 1'b1,
    localparam int N         = OUT_W / IN_W,
    localparam int CNT_W     = cnt_w(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             overrun
);

    if (!cfg_ok(IN_W, OUT_W)) begin : g_bad_cfg
        $error("sipo_deser: OUT_W must be a multiple of IN_W with at least two beats");
    end

    logic [OUT_W-1:0] fill_q, fill_d, fill_next;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic             last_beat;
    logic             accept;
    logic             complete;

    assign last_beat = (cnt_q == CNT_W'(N - 1));
    assign accept    = in_valid && in_ready && !clear;
    assign complete  = accept && last_beat;

    // fill_next is the fill register with the current beat shifted in; on the
    // last beat it is the finished word, so it also feeds the output stage.
    assign fill_next = MSB_FIRST ? {fill_q[OUT_W-IN_W-1:0], in_data}
                                 : {in_data, fill_q[OUT_W-1:IN_W]};

    always_comb begin
        fill_d = fill_q;
        cnt_d  = cnt_q;
        ovr_d  = ovr_q;
        if (clear) begin
            fill_d = '0;
            cnt_d  = '0;
            ovr_d  = 1'b0;
        end else begin
            if (in_valid && !in_ready) begin
                ovr_d = 1'b1;
            end
            // The fill register is not zeroed at wrap: the next frame's N
            // shifts push every stale bit out before the word is used.
            if (accept) begin
                fill_d = fill_next;
                cnt_d  = last_beat ? '0 : cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fill_q <= '0;
            cnt_q  <= '0;
            ovr_q  <= 1'b0;
        end else begin
            fill_q <= fill_d;
            cnt_q  <= cnt_d;
            ovr_q  <= ovr_d;
        end
    end

    sipo_out_reg #(
        .OUT_W (OUT_W)
    ) u_out_reg (
        .clk       (clk),
        .rst_n     (reset),
        .clear     (clear),
        .load      (complete),
        .load_data (fill_next),
        .last_beat (last_beat),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .in_ready  (in_ready)
    );

    assign beat_cnt = cnt_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - self-checking bench for sipo_deser
module tb_sipo_deser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, clear, in_valid, out_ready;
    logic [1:0] in_data;

    logic       in_ready0, out_valid0, overrun0;
    logic [7:0] out_data0;
    logic [1:0] beat_cnt0;
    logic       in_ready1, out_valid1, overrun1;
    logic [7:0] out_data1;
    logic [1:0] beat_cnt1;

    logic [2:0]  s_valid;
    logic [0:0]  sd2;
    logic [3:0]  sd3;
    logic [7:0]  sd4;
    logic        ir2, ov2, or2;
    logic [7:0]  od2;
    logic [2:0]  bc2;
    logic        ir3, ov3, or3;
    logic [31:0] od3;
    logic [2:0]  bc3;
    logic        ir4, ov4, or4;
    logic [15:0] od4;
    logic [0:0]  bc4;

    sipo_deser #(.IN_W(2), .OUT_W(8), .MSB_FIRST(1'b1)) d0 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready0), .out_valid(out_valid0), .out_data(out_data0),
        .out_ready(out_ready), .beat_cnt(beat_cnt0), .overrun(overrun0));

    sipo_deser #(.IN_W(2), .OUT_W(8), .MSB_FIRST(1'b0)) d1 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready), .beat_cnt(beat_cnt1), .overrun(overrun1));

    sipo_deser #(.IN_W(1), .OUT_W(8), .MSB_FIRST(1'b1)) d2 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(s_valid[0]), .in_data(sd2),
        .in_ready(ir2), .out_valid(ov2), .out_data(od2),
        .out_ready(out_ready), .beat_cnt(bc2), .overrun(or2));

    sipo_deser #(.IN_W(4), .OUT_W(32), .MSB_FIRST(1'b1)) d3 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(s_valid[1]), .in_data(sd3),
        .in_ready(ir3), .out_valid(ov3), .out_data(od3),
        .out_ready(out_ready), .beat_cnt(bc3), .overrun(or3));

    sipo_deser #(.IN_W(8), .OUT_W(16), .MSB_FIRST(1'b1)) d4 (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(s_valid[2]), .in_data(sd4),
        .in_ready(ir4), .out_valid(ov4), .out_data(od4),
        .out_ready(out_ready), .beat_cnt(bc4), .overrun(or4));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model for d0/d1: a list of accepted beats. A word is the
    // positional sum of its four beats; whether the output holds a word is a
    // single flag. Updated at each falling edge to predict the next rising edge.
    int       m_beats[$];
    bit       m_full;
    bit       m_ovr;
    int       m_word0, m_word1;
    int       words_seen;
    int       ready_low;
    bit       m_rdy, m_drain;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            m_beats.delete();
            m_full  = 1'b0;
            m_ovr   = 1'b0;
            m_word0 = 0;
            m_word1 = 0;
        end else begin
            m_rdy = !(m_beats.size() == 3 && m_full && !out_ready);
            chk("m_out_valid0", out_valid0, m_full);
            chk("m_out_valid1", out_valid1, m_full);
            if (m_full) begin
                chk("m_out_data_msb", out_data0, m_word0);
                chk("m_out_data_lsb", out_data1, m_word1);
            end
            chk("m_beat_cnt", beat_cnt0, m_beats.size());
            chk("m_in_ready", in_ready0, m_rdy);
            chk("m_overrun", overrun0, m_ovr);
            if (out_valid0) words_seen++;
            if (!in_ready0) ready_low++;

            if (clear) begin
                m_beats.delete();
                m_full  = 1'b0;
                m_ovr   = 1'b0;
                m_word0 = 0;
                m_word1 = 0;
            end else begin
                m_drain = m_full && out_ready;
                if (in_valid && !m_rdy) m_ovr = 1'b1;
                if (in_valid && m_rdy) begin
                    m_beats.push_back(int'(in_data));
                    if (m_beats.size() == 4) begin
                        m_word0 = 0;
                        m_word1 = 0;
                        for (int i = 0; i < 4; i++) begin
                            m_word0 += m_beats[i] * (1 << (2 * (3 - i)));
                            m_word1 += m_beats[i] * (1 << (2 * i));
                        end
                        m_beats.delete();
                        m_full = 1'b1;
                    end else if (m_drain) begin
                        m_full = 1'b0;
                    end
                end else if (m_drain) begin
                    m_full = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = 2'($urandom_range(0, 3));
            step();
        end
        in_valid = 1'b0;
    endtask

    task automatic sweep(input int k);
        int          iw, n;
        longint      exp;
        logic [7:0]  bv;
        logic        gv;
        logic [31:0] got;
        iw  = (k == 0) ? 1 : ((k == 1) ? 4 : 8);
        n   = (k == 0) ? 8 : ((k == 1) ? 8 : 2);
        exp = 0;
        out_ready = 1'b1;
        s_valid[k] = 1'b1;
        for (int i = 0; i < n; i++) begin
            bv  = 8'($urandom_range(0, (1 << iw) - 1));
            exp = exp + (longint'(bv) << (iw * (n - 1 - i)));
            sd2 = bv[0:0];
            sd3 = bv[3:0];
            sd4 = bv;
            step();
        end
        s_valid[k] = 1'b0;
        @(negedge clk);
        case (k)
            0: begin gv = ov2; got = 32'(od2); end
            1: begin gv = ov3; got = od3; end
            default: begin gv = ov4; got = 32'(od4); end
        endcase
        chk($sformatf("sweep%0d_valid", k), gv, 1);
        chk($sformatf("sweep%0d_data", k), got, exp);
        @(negedge clk);
        case (k)
            0: gv = ov2;
            1: gv = ov3;
            default: gv = ov4;
        endcase
        chk($sformatf("sweep%0d_pulse", k), gv, 0);
    endtask

    int w0, r0;
    int fixed_beats[4] = '{3, 0, 2, 1};

    initial begin
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        s_valid = '0; sd2 = '0; sd3 = '0; sd4 = '0;
        #1;
        chk("rst_out_valid", out_valid0, 0);
        chk("rst_out_data", out_data0, 0);
        chk("rst_beat_cnt", beat_cnt0, 0);
        chk("rst_overrun", overrun0, 0);
        chk("rst_in_ready", in_ready0, 1);
        step(); step();
        reset = 1'b1;
        step();

        // In-order fill with the fixed beat pattern.
        for (int i = 0; i < 4; i++) begin
            chk("fill_beat_cnt", beat_cnt0, i);
            in_valid = 1'b1;
            in_data  = 2'(fixed_beats[i]);
            step();
        end
        in_valid = 1'b0;
        chk("fill_wrap_cnt", beat_cnt0, 0);
        chk("fill_valid", out_valid0, 1);
        chk("fill_msb_word", out_data0, 8'hC9);
        chk("fill_lsb_word", out_data1, 8'h63);
        step();
        chk("fill_one_cycle", out_valid0, 0);

        // Backpressure: eight offered beats against a stalled consumer.
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 2'($urandom_range(0, 3));
            step();
        end
        chk("bp_valid", out_valid0, 1);
        chk("bp_cnt", beat_cnt0, 3);
        chk("bp_in_ready", in_ready0, 0);
        chk("bp_overrun", overrun0, 1);
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("bp_reload_valid", out_valid0, 1);
        chk("bp_reload_cnt", beat_cnt0, 0);
        step(); step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_overrun", overrun0, 0);

        // Sustained full-rate streaming.
        w0 = words_seen;
        r0 = ready_low;
        send(64);
        step();
        chk("rate_words", words_seen - w0, 16);
        chk("rate_ready_low", ready_low - r0, 0);

        // clear mid-frame with a beat in the same cycle.
        send(2);
        in_valid = 1'b1;
        in_data  = 2'($urandom_range(0, 3));
        clear    = 1'b1;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_cnt", beat_cnt0, 0);
        chk("clr_valid", out_valid0, 0);
        chk("clr_data", out_data0, 0);
        send(4);
        chk("clr_next_valid", out_valid0, 1);
        step();

        // Asynchronous reset mid-frame.
        send(3);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_valid", out_valid0, 0);
        chk("arst_data", out_data0, 0);
        chk("arst_cnt", beat_cnt0, 0);
        chk("arst_overrun", overrun0, 0);
        chk("arst_in_ready", in_ready0, 1);
        step();
        reset = 1'b1;
        step();
        chk("arst_no_word", out_valid0, 0);
        send(4);
        chk("arst_fresh_valid", out_valid0, 1);
        step();

        // Parameter sweep of the in-order fill.
        for (int k = 0; k < 3; k++) begin
            sweep(k);
        end
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
